// File: rtl/step_sequencer.sv
`default_nettype none
// =============================================================================
// step_sequencer: plays a programmable table of {fstep, dur} steps, one-shot or looped.
// Optional macro STEP_SEQ_SYNC_EN puts a two-flop synchronizer on startbutton_i.
// Revision: 1.0
// =============================================================================
module step_sequencer #(
    parameter int WIDTH_P       = 32,
    parameter int DEPTH_P       = 16,
    parameter int DUR_W_P       = 8,
    parameter int TICK_CYCLES_P = 25000000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       startbutton_i,
    input  logic                       loop_i,
    input  logic                       wr_v_i,
    input  logic [$clog2(DEPTH_P)-1:0] wr_addr_i,
    input  logic [WIDTH_P-1:0]         wr_fstep_i,
    input  logic [DUR_W_P-1:0]         wr_dur_i,
    output logic [WIDTH_P-1:0]         fstep_o,
    output logic                       tick_o,
    output logic [$clog2(DEPTH_P)-1:0] step_idx_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int IDX_W = $clog2(DEPTH_P);
    localparam int TCW   = $clog2(TICK_CYCLES_P);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH_P - 1);
    localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_CYCLES_P - 1);
    localparam logic [TCW-1:0]   TICK_PRE  = TCW'(TICK_CYCLES_P - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Start input conditioning
    // ------------------------------------------------------------------------
    logic start_in;
    logic start_vld;

`ifdef STEP_SEQ_SYNC_EN
    logic [1:0] sync_q, sync_d;
    logic [1:0] vld_q,  vld_d;

    // vld tracks when the synchronizer output reflects the real button again.
    always_comb begin
        sync_d = {sync_q[0], startbutton_i};
        vld_d  = {vld_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
        end
    end

    assign start_in  = sync_q[1];
    assign start_vld = vld_q[1];
`else
    assign start_in  = startbutton_i;
    assign start_vld = 1'b1;
`endif

    logic start_prev_q, start_prev_d;
    logic armed_q, armed_d;
    logic start_evt;

    // A button held through reset must be seen released before it can start.
    always_comb begin
        start_prev_d = start_in;
        armed_d      = armed_q | (start_vld & ~start_in);
    end

    assign start_evt = start_in & ~start_prev_q & armed_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            armed_q      <= armed_d;
        end
    end

    // ------------------------------------------------------------------------
    // Step table; reads see the pre-write contents during a write cycle
    // ------------------------------------------------------------------------
    logic [WIDTH_P-1:0] tab_fstep_q [DEPTH_P];
    logic [WIDTH_P-1:0] tab_fstep_d [DEPTH_P];
    logic [DUR_W_P-1:0] tab_dur_q   [DEPTH_P];
    logic [DUR_W_P-1:0] tab_dur_d   [DEPTH_P];

    always_comb begin
        tab_fstep_d = tab_fstep_q;
        tab_dur_d   = tab_dur_q;
        if (wr_v_i) begin
            tab_fstep_d[wr_addr_i] = wr_fstep_i;
            tab_dur_d[wr_addr_i]   = wr_dur_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                tab_fstep_q[i] <= '0;
                tab_dur_q[i]   <= '0;
            end
        end else begin
            tab_fstep_q <= tab_fstep_d;
            tab_dur_q   <= tab_dur_d;
        end
    end

    // ------------------------------------------------------------------------
    // Playback FSM
    // ------------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [WIDTH_P-1:0] fstep_q,    fstep_d;
    logic [DUR_W_P-1:0] cur_dur_q,  cur_dur_d;
    logic [TCW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [DUR_W_P-1:0] dur_cnt_q,  dur_cnt_d;
    logic               tick_q,     tick_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic             load_v;
    logic [IDX_W-1:0] load_idx;
    logic             go_idle;
    logic [IDX_W-1:0] next_idx;
    logic             step_end;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fstep_d    = fstep_q;
        cur_dur_d  = cur_dur_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        tick_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_v     = 1'b0;
        load_idx   = '0;
        go_idle    = 1'b0;
        next_idx   = idx_q + 1'b1;
        // dur_cnt_q advances together with tick_q, so equality marks the final tick.
        step_end   = tick_q && (dur_cnt_q == cur_dur_q);

        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    if (tab_dur_q[0] != '0) begin
                        load_v = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (start_evt) begin
                    go_idle = 1'b1;
                end else if (step_end) begin
                    if ((idx_q == IDX_LAST) || (tab_dur_q[next_idx] == '0)) begin
                        if (loop_i && (tab_dur_q[0] != '0)) begin
                            load_v = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                            done_d  = 1'b1;
                        end
                    end else begin
                        load_v   = 1'b1;
                        load_idx = next_idx;
                    end
                end else begin
                    tick_d     = (tick_cnt_q == TICK_PRE);
                    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
                    if (tick_d) begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (load_v) begin
            state_d    = ST_PLAY;
            idx_d      = load_idx;
            fstep_d    = tab_fstep_q[load_idx];
            cur_dur_d  = tab_dur_q[load_idx];
            tick_cnt_d = '0;
            dur_cnt_d  = '0;
            busy_d     = 1'b1;
        end

        if (go_idle) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            fstep_d    = '0;
            cur_dur_d  = '0;
            tick_cnt_d = '0;
            dur_cnt_d  = '0;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            fstep_q    <= '0;
            cur_dur_q  <= '0;
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fstep_q    <= fstep_d;
            cur_dur_q  <= cur_dur_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fstep_o    = fstep_q;
    assign tick_o     = tick_q;
    assign step_idx_o = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// =============================================================================
// tb_step_sequencer: directed self-checking bench, TICK_CYCLES_P=4, DEPTH_P=4.
// Revision: 1.0
// =============================================================================
module tb_step_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        startbutton_i = 1'b0;
    logic        loop_i = 1'b0;
    logic        wr_v_i = 1'b0;
    logic [1:0]  wr_addr_i = '0;
    logic [15:0] wr_fstep_i = '0;
    logic [7:0]  wr_dur_i = '0;
    logic [15:0] fstep_o;
    logic        tick_o;
    logic [1:0]  step_idx_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    step_sequencer #(
        .WIDTH_P      (16),
        .DEPTH_P      (4),
        .DUR_W_P      (8),
        .TICK_CYCLES_P(4)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .startbutton_i(startbutton_i),
        .loop_i       (loop_i),
        .wr_v_i       (wr_v_i),
        .wr_addr_i    (wr_addr_i),
        .wr_fstep_i   (wr_fstep_i),
        .wr_dur_i     (wr_dur_i),
        .fstep_o      (fstep_o),
        .tick_o       (tick_o),
        .step_idx_o   (step_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Called at a falling edge; leaves the strobe low at the next falling edge.
    task automatic wr(input int a, input int f, input int d);
        wr_v_i     = 1'b1;
        wr_addr_i  = a[1:0];
        wr_fstep_i = f[15:0];
        wr_dur_i   = d[7:0];
        @(negedge clk_i);
        wr_v_i = 1'b0;
    endtask

    task automatic load_table3();
        wr(0, 100, 2);
        wr(1, 200, 1);
        wr(2, 0, 0);
        wr(3, 0, 0);
    endtask

    // Press-and-release abort, leaves the block idle with the button low.
    task automatic stop_play();
        startbutton_i = 1'b1;
        @(negedge clk_i);
        startbutton_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (1) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_async got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp all 0",
                     busy_o, done_o, tick_o, step_idx_o, fstep_o);
        end
        checks++;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_idle got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp all 0",
                     busy_o, done_o, tick_o, step_idx_o, fstep_o);
        end
        checks++;
    endtask

    task automatic test_oneshot();
        logic eb, ed, et;
        logic [1:0] ei;
        logic [15:0] ef;
        load_table3();
        loop_i = 1'b0;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_i);
            startbutton_i = 1'b0;
            eb = (k <= 12);
            ed = (k == 13);
            et = (k <= 12) && (k % 4 == 0);
            ei = (k >= 9 && k <= 12) ? 2'd1 : 2'd0;
            ef = (k <= 8) ? 16'd100 : (k <= 12) ? 16'd200 : 16'd0;
            if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== {eb, ed, et, ei, ef}) begin
                errors++;
                $display("FAIL oneshot k=%0d got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp %0b/%0b/%0b/%0d/%0d",
                         k, busy_o, done_o, tick_o, step_idx_o, fstep_o, eb, ed, et, ei, ef);
            end
            checks++;
        end
    endtask

    task automatic test_loop();
        logic et;
        logic [1:0] ei;
        logic [15:0] ef;
        int ph;
        load_table3();
        loop_i = 1'b1;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk_i);
            startbutton_i = 1'b0;
            ph = (k - 1) % 12;
            et = (k % 4 == 0);
            ei = (ph < 8) ? 2'd0 : 2'd1;
            ef = (ph < 8) ? 16'd100 : 16'd200;
            if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== {1'b1, 1'b0, et, ei, ef}) begin
                errors++;
                $display("FAIL loop k=%0d got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp 1/0/%0b/%0d/%0d",
                         k, busy_o, done_o, tick_o, step_idx_o, fstep_o, et, ei, ef);
            end
            checks++;
        end
        stop_play();
        loop_i = 1'b0;
    endtask

    task automatic test_abort();
        load_table3();
        loop_i = 1'b0;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk_i);
            if (k >= 11) begin
                if ({busy_o, done_o, step_idx_o, fstep_o} !== 20'd0) begin
                    errors++;
                    $display("FAIL abort k=%0d got b/d/idx/f=%0b/%0b/%0d/%0d exp 0/0/0/0",
                             k, busy_o, done_o, step_idx_o, fstep_o);
                end
                checks++;
            end else if (k == 10) begin
                if ({busy_o, step_idx_o, fstep_o} !== {1'b1, 2'd1, 16'd200}) begin
                    errors++;
                    $display("FAIL abort_pre got b/idx/f=%0b/%0d/%0d exp 1/1/200",
                             busy_o, step_idx_o, fstep_o);
                end
                checks++;
            end
            startbutton_i = (k == 10);
        end
        startbutton_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_wrap();
        logic eb, ed, et;
        logic [1:0] ei;
        logic [15:0] ef;
        wr(0, 10, 1);
        wr(1, 20, 1);
        wr(2, 30, 1);
        wr(3, 40, 1);
        loop_i = 1'b0;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_i);
            startbutton_i = 1'b0;
            eb = (k <= 16);
            ed = (k == 17);
            et = (k <= 16) && (k % 4 == 0);
            ei = (k <= 16) ? 2'((k - 1) / 4) : 2'd0;
            ef = (k <= 16) ? 16'(10 * ((k - 1) / 4 + 1)) : 16'd0;
            if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== {eb, ed, et, ei, ef}) begin
                errors++;
                $display("FAIL wrap k=%0d got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp %0b/%0b/%0b/%0d/%0d",
                         k, busy_o, done_o, tick_o, step_idx_o, fstep_o, eb, ed, et, ei, ef);
            end
            checks++;
        end
    endtask

    task automatic test_empty();
        wr(0, 5, 0);
        startbutton_i = 1'b1;
        @(negedge clk_i);
        startbutton_i = 1'b0;
        if ({busy_o, done_o, fstep_o} !== {1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL empty_start got b/d/f=%0b/%0b/%0d exp 0/1/0", busy_o, done_o, fstep_o);
        end
        checks++;
        @(negedge clk_i);
        if ({busy_o, done_o} !== 2'b00) begin
            errors++;
            $display("FAIL empty_after got b/d=%0b/%0b exp 0/0", busy_o, done_o);
        end
        checks++;
    endtask

    task automatic test_rewrite();
        logic [1:0] ei;
        logic [15:0] ef;
        load_table3();
        loop_i = 1'b1;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            startbutton_i = 1'b0;
            wr_v_i = 1'b0;
            ei = ((k >= 9 && k <= 12) || k >= 17) ? 2'd1 : 2'd0;
            ef = (k <= 8) ? 16'd100 : (k <= 12) ? 16'd200 : (k <= 16) ? 16'd555 : 16'd200;
            if ({busy_o, done_o, step_idx_o, fstep_o} !== {1'b1, 1'b0, ei, ef}) begin
                errors++;
                $display("FAIL rewrite k=%0d got b/d/idx/f=%0b/%0b/%0d/%0d exp 1/0/%0d/%0d",
                         k, busy_o, done_o, step_idx_o, fstep_o, ei, ef);
            end
            checks++;
            if (k == 2) begin
                wr_v_i = 1'b1; wr_addr_i = 2'd0; wr_fstep_i = 16'd555; wr_dur_i = 8'd1;
            end
        end
        stop_play();
        loop_i = 1'b0;
    endtask

    task automatic test_collide();
        logic [1:0] ei;
        logic [15:0] ef;
        int ph;
        load_table3();
        loop_i = 1'b1;
        startbutton_i = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk_i);
            startbutton_i = 1'b0;
            wr_v_i = 1'b0;
            ph = (k - 1) % 12;
            if (k <= 24) begin
                ei = (ph < 8) ? 2'd0 : 2'd1;
                ef = (ph < 8) ? 16'd100 : 16'd200;
            end else begin
                ei = (k <= 28) ? 2'd0 : 2'd1;
                ef = (k <= 28) ? 16'd777 : 16'd200;
            end
            if ({busy_o, done_o, step_idx_o, fstep_o} !== {1'b1, 1'b0, ei, ef}) begin
                errors++;
                $display("FAIL collide k=%0d got b/d/idx/f=%0b/%0b/%0d/%0d exp 1/0/%0d/%0d",
                         k, busy_o, done_o, step_idx_o, fstep_o, ei, ef);
            end
            checks++;
            if (k == 12) begin
                wr_v_i = 1'b1; wr_addr_i = 2'd0; wr_fstep_i = 16'd777; wr_dur_i = 8'd1;
            end
        end
        stop_play();
        loop_i = 1'b0;
    endtask

    task automatic test_reset_midplay();
        load_table3();
        loop_i = 1'b0;
        startbutton_i = 1'b1;
        repeat (5) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        if ({busy_o, done_o, tick_o, step_idx_o, fstep_o} !== 21'd0) begin
            errors++;
            $display("FAIL midreset_async got b/d/t/idx/f=%0b/%0b/%0b/%0d/%0d exp all 0",
                     busy_o, done_o, tick_o, step_idx_o, fstep_o);
        end
        checks++;
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if ({busy_o, done_o, fstep_o} !== 18'd0) begin
                errors++;
                $display("FAIL held_button k=%0d got b/d/f=%0b/%0b/%0d exp 0/0/0",
                         k, busy_o, done_o, fstep_o);
            end
            checks++;
        end
        startbutton_i = 1'b0;
        @(negedge clk_i);
        // Table was cleared by reset, so a fresh press sees an empty sequence.
        startbutton_i = 1'b1;
        @(negedge clk_i);
        startbutton_i = 1'b0;
        if ({busy_o, done_o} !== 2'b01) begin
            errors++;
            $display("FAIL table_cleared got b/d=%0b/%0b exp 0/1", busy_o, done_o);
        end
        checks++;
        load_table3();
        startbutton_i = 1'b1;
        @(negedge clk_i);
        startbutton_i = 1'b0;
        if ({busy_o, step_idx_o, fstep_o} !== {1'b1, 2'd0, 16'd100}) begin
            errors++;
            $display("FAIL repress got b/idx/f=%0b/%0d/%0d exp 1/0/100", busy_o, step_idx_o, fstep_o);
        end
        checks++;
        stop_play();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_abort();
        test_wrap();
        test_empty();
        test_rewrite();
        test_collide();
        test_reset_midplay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
